// File: rtl/spiral_frame_loader.sv
// Header-framed stream loader: decodes row/col from a header word, then forwards
// exactly row*col payload elements to the spiral stage through a registered output.
module spiral_frame_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int R_WIDTH    = 3,
    parameter int C_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_rdy,
    output logic [R_WIDTH-1:0]    row,
    output logic [C_WIDTH-1:0]    col,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_rdy,
    output logic                  data_out_last,
    output logic                  frame_done,
    output logic                  zero_frame
);
    localparam int NW = R_WIDTH + C_WIDTH;

    typedef enum logic [1:0] {HDR, DATA, LAST} state_t;

    state_t                r_state, w_state_nxt;
    logic [R_WIDTH-1:0]    r_row, w_row_nxt;
    logic [C_WIDTH-1:0]    r_col, w_col_nxt;
    logic [NW-1:0]         r_count, w_count_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_last, w_last_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic                  r_zero_frame, w_zero_frame_nxt;
    logic                  w_rdy;
    logic [R_WIDTH-1:0]    w_hdr_row;
    logic [C_WIDTH-1:0]    w_hdr_col;
    logic [NW-1:0]         w_n;

    assign w_hdr_row = s_data[NW-1:C_WIDTH];
    assign w_hdr_col = s_data[C_WIDTH-1:0];
    // Product at full field width so the largest frame never wraps.
    assign w_n       = NW'(w_hdr_row) * NW'(w_hdr_col);

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_count_nxt      = r_count;
        w_data_nxt       = r_data;
        w_valid_nxt      = r_valid;
        w_last_nxt       = r_last;
        w_frame_done_nxt = 1'b0;
        w_zero_frame_nxt = 1'b0;
        w_rdy            = 1'b0;
        case (r_state)
            HDR: begin
                w_rdy = 1'b1;
                if (s_valid) begin
                    if (w_n == '0) begin
                        w_zero_frame_nxt = 1'b1;
                    end else begin
                        w_row_nxt   = w_hdr_row;
                        w_col_nxt   = w_hdr_col;
                        w_count_nxt = w_n;
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                w_rdy = !r_valid || data_out_rdy;
                if (r_valid && data_out_rdy) begin
                    w_valid_nxt = 1'b0;
                end
                // An accept in the same cycle as a drain overwrites with no bubble.
                if (s_valid && w_rdy) begin
                    w_data_nxt  = s_data;
                    w_valid_nxt = 1'b1;
                    w_count_nxt = r_count - NW'(1);
                    if (r_count == NW'(1)) begin
                        w_last_nxt  = 1'b1;
                        w_state_nxt = LAST;
                    end
                end
            end
            LAST: begin
                if (data_out_rdy) begin
                    w_valid_nxt      = 1'b0;
                    w_last_nxt       = 1'b0;
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = HDR;
                end
            end
            default: w_state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= HDR;
            r_row        <= '0;
            r_col        <= '0;
            r_count      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_zero_frame <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_count      <= w_count_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_last       <= w_last_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_zero_frame <= w_zero_frame_nxt;
        end
    end

    assign s_rdy          = w_rdy && rstn;
    assign row            = r_row;
    assign col            = r_col;
    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign data_out_last  = r_last;
    assign frame_done     = r_frame_done;
    assign zero_frame     = r_zero_frame;

endmodule
